// File: rtl/baud_gen_frac_pkg.sv
// Shared defaults and helpers for the fractional baud-rate generator.
// Holds the parameter defaults and the os_phase width function.
package baud_gen_frac_pkg;

   localparam int CNT_WIDTH_DEF  = 13;
   localparam int FRAC_WIDTH_DEF = 3;
   localparam int OVERSAMPLE_DEF = 16;

   // Ceiling log2, never less than 1 so a phase port always has a bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator with oversample phase counter.
// Ticks every baud_val+1 clocks, stretched by one clock whenever the fraction accumulator carries.
module baud_gen_frac
   import baud_gen_frac_pkg::*;
#(
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
   parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic                          restart,
   input  logic [CNT_WIDTH-1:0]          baud_val,
   input  logic [FRAC_WIDTH-1:0]         baud_frac,
   output logic                          baud_clock,
   output logic                          xmit_pulse,
   output logic [clog2(OVERSAMPLE)-1:0]  os_phase
);

   localparam int                 OS_W    = clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0]    OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]    OS_ONE  = OS_W'(1);
   localparam logic [CNT_WIDTH:0] CNT_ONE = (CNT_WIDTH + 1)'(1);

   logic [CNT_WIDTH:0]  cnt;
   logic [FRAC_WIDTH-1:0] acc;
   logic [FRAC_WIDTH:0] acc_sum;
   logic [OS_W-1:0]     os_cntr;
   logic                clear;
   logic                reload;

   assign clear   = restart | ~enable;
   assign reload  = (cnt == '0);
   assign acc_sum = {1'b0, acc} + {1'b0, baud_frac};

   // Extra bit on cnt lets an all-ones baud_val plus carry reload without wrapping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         baud_clock <= 1'b0;
      end else if (clear) begin
         cnt        <= '0;
         baud_clock <= 1'b0;
      end else if (reload) begin
         cnt        <= {1'b0, baud_val} + (CNT_WIDTH + 1)'(acc_sum[FRAC_WIDTH]);
         baud_clock <= 1'b1;
      end else begin
         cnt        <= cnt - CNT_ONE;
         baud_clock <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (reload) begin
         acc <= acc_sum[FRAC_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         os_cntr <= '0;
      end else if (clear) begin
         os_cntr <= '0;
      end else if (baud_clock) begin
         os_cntr <= (os_cntr == OS_LAST) ? '0 : os_cntr + OS_ONE;
      end
   end

   assign xmit_pulse = baud_clock & (os_cntr == OS_LAST);
   assign os_phase   = os_cntr;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: default instance plus a FRAC_WIDTH=4 / OVERSAMPLE=12 instance.
// Expected tick times, phases and bit pulses are queued ahead and matched as ticks appear.
module tb_baud_gen_frac;

   typedef struct {
      int cyc;
      int os;
      int xm;
   } tick_t;

   logic        clk = 1'b0;
   logic        reset_n;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   logic        en_a, rs_a;
   logic [12:0] bv_a;
   logic [2:0]  bf_a;
   logic        bc_a, xp_a;
   logic [3:0]  osp_a;

   logic        en_b, rs_b;
   logic [12:0] bv_b;
   logic [3:0]  bf_b;
   logic        bc_b, xp_b;
   logic [3:0]  osp_b;

   tick_t q_a[$];
   tick_t q_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   baud_gen_frac u_def (
      .clk(clk), .reset_n(reset_n), .enable(en_a), .restart(rs_a),
      .baud_val(bv_a), .baud_frac(bf_a),
      .baud_clock(bc_a), .xmit_pulse(xp_a), .os_phase(osp_a)
   );

   baud_gen_frac #(.CNT_WIDTH(13), .FRAC_WIDTH(4), .OVERSAMPLE(12)) u_alt (
      .clk(clk), .reset_n(reset_n), .enable(en_b), .restart(rs_b),
      .baud_val(bv_b), .baud_frac(bf_b),
      .baud_clock(bc_b), .xmit_pulse(xp_b), .os_phase(osp_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Tick k+1 follows tick k by bval+1 clocks plus one whenever floor(k*frac/2^fw) steps up.
   task automatic push_plan(input int which, input int start, input int bval, input int frac,
                            input int fw, input int osn, input int os0, input int n,
                            output int last);
      tick_t t;
      int    tc;
      int    carry;
      tc = start;
      for (int k = 0; k < n; k++) begin
         t.cyc = tc;
         t.os  = (os0 + k) % osn;
         t.xm  = (t.os == osn - 1) ? 1 : 0;
         if (which == 0) q_a.push_back(t);
         else            q_b.push_back(t);
         last  = tc;
         carry = (((k + 1) * frac) >> fw) - ((k * frac) >> fw);
         tc    = tc + bval + 1 + carry;
      end
   endtask

   task automatic step_to(input int target);
      for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk);
      chk("step_to", cyc, target);
   endtask

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (bc_a === 1'b1) begin
            if (q_a.size() == 0) begin
               chk("a_unexpected_tick_cyc", cyc, 32'hFFFF_FFFF);
            end else begin
               tick_t e;
               e = q_a.pop_front();
               chk("a_tick_cyc", cyc, e.cyc);
               chk("a_tick_os", osp_a, e.os);
               chk("a_tick_xmit", xp_a, e.xm);
            end
         end else begin
            chk("a_idle_xmit", xp_a, 0);
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (bc_b === 1'b1) begin
            if (q_b.size() == 0) begin
               chk("b_unexpected_tick_cyc", cyc, 32'hFFFF_FFFF);
            end else begin
               tick_t e;
               e = q_b.pop_front();
               chk("b_tick_cyc", cyc, e.cyc);
               chk("b_tick_os", osp_b, e.os);
               chk("b_tick_xmit", xp_b, e.xm);
            end
         end else begin
            chk("b_idle_xmit", xp_b, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int last;
      int t0;
      reset_n = 1'b0;
      en_a = 1'b0; rs_a = 1'b0; bv_a = '0; bf_a = '0;
      en_b = 1'b0; rs_b = 1'b0; bv_b = '0; bf_b = '0;
      #1;
      chk("reset_bc_a", bc_a, 0);
      chk("reset_xp_a", xp_a, 0);
      chk("reset_os_a", osp_a, 0);
      chk("reset_bc_b", bc_b, 0);
      chk("reset_os_b", osp_b, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Integer divide by 4, 16x oversample: ticks every 4, bit pulse every 64.
      bv_a = 13'd3; bf_a = 3'd0; en_a = 1'b1;
      push_plan(0, cyc + 1, 3, 0, 3, 16, 0, 40, last);
      step_to(last);
      en_a = 1'b0;
      @(negedge clk);
      chk("dis_bc_a", bc_a, 0);
      chk("dis_os_a", osp_a, 0);
      chk("q_a_empty_int", q_a.size(), 0);

      // Fractional 3 + 3/8.
      bv_a = 13'd2; bf_a = 3'd3; en_a = 1'b1;
      push_plan(0, cyc + 1, 2, 3, 3, 16, 0, 24, last);
      step_to(last);
      en_a = 1'b0;
      @(negedge clk);
      chk("q_a_empty_frac", q_a.size(), 0);

      // Divisor change mid-period takes effect at the next reload.
      bv_a = 13'd9; bf_a = 3'd0; en_a = 1'b1;
      t0 = cyc + 1;
      push_plan(0, t0, 9, 0, 3, 16, 0, 2, last);
      push_plan(0, t0 + 20, 2, 0, 3, 16, 2, 8, last);
      step_to(t0 + 15);
      bv_a = 13'd2;
      step_to(last);
      en_a = 1'b0;
      @(negedge clk);
      chk("q_a_empty_chg", q_a.size(), 0);

      // Restart at os_phase 7, then restart colliding with a reload.
      bv_a = 13'd3; en_a = 1'b1;
      t0 = cyc + 1;
      push_plan(0, t0, 3, 0, 3, 16, 0, 7, last);
      step_to(t0 + 26);
      chk("pre_restart_os", osp_a, 7);
      rs_a = 1'b1;
      @(negedge clk);
      rs_a = 1'b0;
      chk("restart_bc", bc_a, 0);
      chk("restart_os", osp_a, 0);
      push_plan(0, t0 + 28, 3, 0, 3, 16, 0, 2, last);
      step_to(t0 + 35);
      rs_a = 1'b1;
      @(negedge clk);
      rs_a = 1'b0;
      chk("restart_reload_bc", bc_a, 0);
      chk("restart_reload_os", osp_a, 0);
      push_plan(0, t0 + 37, 3, 0, 3, 16, 0, 3, last);
      step_to(last);
      en_a = 1'b0;
      @(negedge clk);
      chk("q_a_empty_rst", q_a.size(), 0);

      // Zero divisor: tick on every cycle.
      bv_a = 13'd0; bf_a = 3'd0; en_a = 1'b1;
      push_plan(0, cyc + 1, 0, 0, 3, 16, 0, 10, last);
      step_to(last);
      en_a = 1'b0;
      @(negedge clk);
      chk("zero_div_stop_bc", bc_a, 0);
      chk("q_a_empty_zero", q_a.size(), 0);

      // Asynchronous reset mid-period, then restart like a fresh enable.
      bv_a = 13'd9; en_a = 1'b1;
      t0 = cyc + 1;
      push_plan(0, t0, 9, 0, 3, 16, 0, 2, last);
      step_to(t0 + 14);
      chk("pre_areset_os", osp_a, 2);
      #2 reset_n = 1'b0;
      #1;
      chk("areset_bc", bc_a, 0);
      chk("areset_xp", xp_a, 0);
      chk("areset_os", osp_a, 0);
      chk("q_a_empty_pre_areset", q_a.size(), 0);
      @(negedge clk);
      reset_n = 1'b1;
      push_plan(0, cyc + 1, 9, 0, 3, 16, 0, 2, last);
      step_to(last);
      en_a = 1'b0;
      @(negedge clk);
      chk("q_a_empty_areset", q_a.size(), 0);

      // Half-clock fraction: periods alternate 4 and 5.
      bv_b = 13'd3; bf_b = 4'd8; en_b = 1'b1;
      push_plan(1, cyc + 1, 3, 8, 4, 12, 0, 32, last);
      step_to(last);
      en_b = 1'b0;
      @(negedge clk);
      chk("q_b_empty_half", q_b.size(), 0);

      // 12x oversample at divide-by-2: bit pulse every 24 clocks.
      bv_b = 13'd1; bf_b = 4'd0; en_b = 1'b1;
      push_plan(1, cyc + 1, 1, 0, 4, 12, 0, 30, last);
      step_to(last);
      en_b = 1'b0;
      @(negedge clk);
      chk("dis_os_b", osp_b, 0);
      chk("q_b_empty_os12", q_b.size(), 0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 The block SHALL provide parameter CNT_WIDTH, default 13, giving the divisor width in bits (legal 8..24).
REQ-002 The block SHALL provide parameter FRAC_WIDTH, default 3, giving the fractional divisor width in bits (legal 1..8).
REQ-003 The block SHALL provide parameter OVERSAMPLE, default 16, giving the baud ticks per bit period (legal 4..32, non-power-of-2 allowed).
REQ-004 The block SHALL provide port clk, input, 1 bit: the system clock; all logic is on its rising edge.
REQ-005 The block SHALL provide port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL provide port enable, input, 1 bit: generator run; low holds the generator in its cleared state.
REQ-007 The block SHALL provide port restart, input, 1 bit: synchronous single-cycle strobe that realigns all counters.
REQ-008 The block SHALL provide port baud_val, input, CNT_WIDTH bits: integer divisor; the tick period is baud_val+1 clocks.
REQ-009 The block SHALL provide port baud_frac, input, FRAC_WIDTH bits: fractional divisor, in units of 1/2^FRAC_WIDTH clock per tick.
REQ-010 The block SHALL provide port baud_clock, output, 1 bit: single-cycle oversample tick.
REQ-011 The block SHALL provide port xmit_pulse, output, 1 bit: single-cycle bit-period pulse, coincident with a baud_clock cycle.
REQ-012 The block SHALL provide port os_phase, output, clog2(OVERSAMPLE) bits: current oversample phase, for receiver mid-bit sampling.

Function
REQ-013 The divisor counter SHALL be CNT_WIDTH+1 bits wide, so that a reload of all-ones plus 1 cannot overflow.
REQ-014 When the counter equals 0 at a clock edge, the block SHALL reload it with baud_val+carry, set baud_clock to 1 for the next cycle, and set acc to (acc+baud_frac) mod 2^FRAC_WIDTH, where carry is the carry-out of acc+baud_frac.
REQ-015 Otherwise, the counter SHALL decrement by 1 and baud_clock SHALL be 0.
REQ-016 The long-run mean tick period SHALL be baud_val+1+baud_frac/2^FRAC_WIDTH clocks, and consecutive tick periods SHALL differ by at most 1 clock.
REQ-017 baud_val and baud_frac SHALL be sampled only at reload; a change mid-period SHALL take effect at the next reload, with no glitch or truncated period.
REQ-018 When baud_val=0 and baud_frac=0, baud_clock SHALL be held high on every cycle.
REQ-019 os_cntr (driven on os_phase) SHALL increment at each edge where baud_clock=1, and SHALL wrap from OVERSAMPLE-1 to 0.
REQ-020 xmit_pulse SHALL equal baud_clock AND (os_cntr==OVERSAMPLE-1), combinationally from registers, so exactly one xmit_pulse occurs per OVERSAMPLE ticks.
REQ-021 When restart=1 or enable=0, the next edge SHALL clear the counter, acc and os_cntr to 0 and set baud_clock to 0; restart and enable=0 have equal effect, and both override reload.
REQ-022 On the first edge with enable=1 and restart=0 after clearing, the block SHALL perform the REQ-014 reload, so baud_clock is high one cycle after enable rises.
REQ-023 When restart coincides with a reload, restart SHALL win and no tick SHALL be emitted.

Reset
REQ-024 On reset_n=0, the counter, acc and os_cntr SHALL be 0 and baud_clock SHALL be 0 immediately, independent of clk, so xmit_pulse=0 and os_phase=0.
REQ-025 Reset assertion mid-period SHALL abort the period; after deassertion, behaviour SHALL match REQ-022.

Structure
REQ-026 A shared package SHALL hold the default values of CNT_WIDTH, FRAC_WIDTH and OVERSAMPLE and the os_phase width function clog2.
REQ-027 The block SHALL be a single module with no sub-module; the divisor counter, fractional accumulator and oversample counter are each one always block.

Verification
REQ-028 Cover: baud_val=3, baud_frac=0 after enable -> baud_clock every 4 clocks, first tick 1 clock after enable, xmit_pulse every 64 clocks, os_phase 0..15.
REQ-029 Cover: baud_val=3, FRAC_WIDTH=4, baud_frac=8 -> tick periods alternate 4,5,4,5, giving 16 ticks in 72 clocks.
REQ-030 Cover: OVERSAMPLE=12, baud_val=1 -> xmit_pulse every 24 clocks, os_phase wrapping from 11 to 0.
REQ-031 Cover: baud_val changed from 9 to 2 mid-period -> the current 10-clock period completes, then 3-clock periods follow.
REQ-032 Cover: restart pulsed at os_phase=7 -> the next edge gives os_phase=0 and baud_clock=0, then a tick 1 clock later.
REQ-033 Cover: reset_n asserted mid-period, and enable=0 -> outputs 0 immediately or next edge respectively; baud_val=0, baud_frac=0 -> baud_clock constantly high.
